histeq_lut_builder: RTL and testbench
=====================================

# histeq_lut_builder

Consumer of the minimum-bin statistic and the histogram memory in the histogram-equalization pipeline. After a frame's histogram is complete and `cdf_min` (the pixel count of the lowest occupied grey level) is known, the block sweeps all bins in order and accumulates the cumulative histogram. For each bin it computes the equalized output level with a sequential divider and writes it into the remap LUT that the pixel-mapping stage uses.

## Interface
- `PixelSize`, default 8: bits per pixel; the block handles 2^PixelSize bins and LUT entries.
- `NumPixels`, default 640*480: pixels per frame.
- `histoWidth`, default $clog2(640*480) = 19: width of bin counts and the CDF.
- `clk`  in  1: the single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: build request. Sampled only in IDLE.
- `cdf_min`  in  histoWidth: minimum nonzero CDF value. Latched on an accepted start.
- `hist_rd_en`  out  1: histogram memory read strobe.
- `hist_rd_addr`  out  PixelSize: bin index.
- `hist_rd_data`  in  histoWidth: bin count, valid exactly 1 cycle after `hist_rd_en`.
- `lut_wr_en`  out  1: LUT write strobe.
- `lut_wr_addr`  out  PixelSize: LUT index, equal to the bin index.
- `lut_wr_data`  out  PixelSize: equalized level.
- `busy`  out  1: high from the cycle after an accepted start through the final write.
- `done`  out  1: one-cycle pulse at completion.

## Operation
- FSM states: IDLE, RD, ACC, DIV, WR.
- **IDLE.** When `start`=1:
  - latch `cdf_min`;
  - clear `cdf`;
  - set `bin`=0;
  - go to RD.
- **RD.** `hist_rd_en`=1 and `hist_rd_addr`=`bin`. Go to ACC.
- **ACC.** `cdf` += `hist_rd_data`, saturating at 2^histoWidth-1. Divider operands are loaded from the new `cdf`:
  - num = (cdf_c − cdf_min)·(2^PixelSize−1) + floor(D/2), where cdf_c = min(cdf, NumPixels);
  - D = NumPixels − cdf_min;
  - the num/D datapath is histoWidth+PixelSize bits wide.
- **DIV.** Restoring divider producing one quotient bit per cycle, PixelSize+1 cycles in total. DIV is always traversed, so latency is data-independent.
- **WR.** One cycle: `lut_wr_en`=1, `lut_wr_addr`=`bin`, `lut_wr_data` = result. The result is forced to 0 in either of these cases:
  - cdf_c ≤ cdf_min (this covers bins below the minimum level);
  - cdf_min ≥ NumPixels (a single-level image, D ≤ 0).
  - Otherwise the quotient is saturated to 2^PixelSize−1.
  - If `bin` is the last bin, go to IDLE and pulse `done`. Otherwise increment `bin` and go to RD.
- `start` is ignored while `busy`=1.
- **Reset values:** all outputs 0, FSM in IDLE, `cdf`=0, `bin`=0.
- **Reset mid-sweep:** all outputs are cleared immediately (asynchronous), and no further writes occur. LUT entries already written are left as they are; the LUT is undefined until the next completed sweep.

## Timing
- Each bin takes PixelSize+4 cycles: RD 1, ACC 1, DIV PixelSize+1, WR 1.
- The first `hist_rd_en` is asserted in the cycle after `start` is sampled.
- `done` is asserted in the cycle after the final `lut_wr_en`. Edge of the accepted start to the `done` cycle is 2^PixelSize·(PixelSize+4)+1 cycles, i.e. 3073 cycles at the defaults.
- `lut_wr_addr` strictly increases from 0 to 2^PixelSize−1, with exactly one write per bin.
- `busy` falls in the same cycle that `done` rises.
- A `start` in the `done` cycle is accepted, because the FSM is already in IDLE.

## Structure
- Shared package `histeq_pkg`:
  - `PixelSize`, `NumPixels` and `histoWidth` constants, shared with the histogram and minimum-bin units;
  - the FSM state enum.
- Sub-module `histeq_seq_divider`: start/done handshake, (histoWidth+PixelSize)-bit dividend, histoWidth-bit divisor, PixelSize+1-bit quotient, fixed PixelSize+1-cycle latency.

## Test plan
- **Uniform:** every bin = 1200, `cdf_min`=1200 → lut[v]=v for all v; lut[0]=0 and lut[255]=255.
- **Single level:** bin 100 = 307200, all others 0, `cdf_min`=307200 → all 256 entries = 0, `done` still at cycle 3073.
- **Two levels:** bin 10 = bin 200 = 153600, `cdf_min`=153600 → lut[0..199]=0 and lut[200..255]=255.
- **Rounding:** bin 0 = 306690, bin 1 = 1, bin 2 = 509, `cdf_min`=306690 → lut[0]=0, lut[1]=1 (exact 0.5 rounds up), lut[2..255]=255.
- **Handshake/timing:**
  - 256 writes, addresses 0..255 in order, 12 cycles apart;
  - `done` pulses exactly 3073 cycles after start;
  - a `start` pulse at cycle 40 leaves the run unchanged.
- **Reset mid-sweep:** assert `reset` at cycle 500 → `busy`, `done`, `hist_rd_en` and `lut_wr_en` are 0 with no clock edge needed. A following start produces a complete 3073-cycle sweep with correct contents.

Source files
------------

// File: rtl/histeq_lut_builder_pkg.sv
// Shared constants and types for the histogram-equalization pipeline.
// Holds the frame geometry (pixel width, pixel count, bin-count width) that
// the histogram, minimum-bin and LUT-builder units share, plus the LUT
// builder FSM state encoding.
package histeq_pkg;

    localparam int PixelSize  = 8;
    localparam int NumPixels  = 640 * 480;
    localparam int histoWidth = $clog2(NumPixels);

    localparam int NumBins  = 1 << PixelSize;
    localparam int MaxLevel = NumBins - 1;
    localparam int DivWidth = histoWidth + PixelSize;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_ACC  = 3'd2,
        ST_DIV  = 3'd3,
        ST_WR   = 3'd4
    } state_e;

endpackage

// File: rtl/histeq_lut_builder_if.sv
// Bus bundle between the LUT builder and its surroundings.
//   start / cdf_min           : build request and the minimum nonzero CDF value
//   hist_rd_en / addr / data  : histogram memory read port (data 1 cycle after en)
//   lut_wr_en / addr / data   : remap LUT write port
//   busy / done               : sweep in progress / one-cycle completion pulse
//   dbg_state                 : current FSM state, for observation only
// Handshake: start is a level sampled only while idle; there is no ready,
// a start seen in IDLE is always accepted. Reads and writes are single-cycle
// strobes with no back-pressure.
interface histeq_lut_builder_if;
    import histeq_pkg::*;

    logic                  start;
    logic [histoWidth-1:0] cdf_min;
    logic                  hist_rd_en;
    logic [PixelSize-1:0]  hist_rd_addr;
    logic [histoWidth-1:0] hist_rd_data;
    logic                  lut_wr_en;
    logic [PixelSize-1:0]  lut_wr_addr;
    logic [PixelSize-1:0]  lut_wr_data;
    logic                  busy;
    logic                  done;
    state_e                dbg_state;

    modport master (
        input  start, cdf_min, hist_rd_data,
        output hist_rd_en, hist_rd_addr, lut_wr_en, lut_wr_addr, lut_wr_data,
        output busy, done, dbg_state
    );

    modport slave (
        output start, cdf_min, hist_rd_data,
        input  hist_rd_en, hist_rd_addr, lut_wr_en, lut_wr_addr, lut_wr_data,
        input  busy, done, dbg_state
    );

endinterface

// File: rtl/histeq_seq_divider.sv
// Restoring divider with a fixed PixelSize+1 cycle latency.
//   start    : loads dividend/divisor (one cycle pulse)
//   dividend : DivWidth-bit numerator
//   divisor  : histoWidth-bit denominator
//   done     : high during the final iteration cycle
//   quotient : PixelSize+1-bit result, valid from the cycle after done
// Only PixelSize+1 quotient bits are produced, so the caller must guarantee
// dividend < divisor * 2^(PixelSize+1). The upper dividend bits therefore
// seed the partial remainder directly and only the low bits are shifted in.
module histeq_seq_divider
    import histeq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DivWidth-1:0]   dividend,
    input  logic [histoWidth-1:0] divisor,
    output logic                  done,
    output logic [PixelSize:0]    quotient
);

    localparam int CntW = $clog2(PixelSize + 1);

    logic [histoWidth-1:0] rem_q, rem_d;
    logic [PixelSize:0]    low_q, low_d;
    logic [PixelSize:0]    quo_q, quo_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic [histoWidth:0]   trial;
    logic                  ge;

    always_comb begin
        rem_d = rem_q;
        low_d = low_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        run_d = run_q;
        trial = {rem_q, low_q[PixelSize]};
        ge    = trial >= {1'b0, divisor};
        done  = run_q && (cnt_q == CntW'(PixelSize));

        if (start) begin
            rem_d = {1'b0, dividend[DivWidth-1:PixelSize+1]};
            low_d = dividend[PixelSize:0];
            quo_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // Restoring step: the partial remainder is below divisor, so the
            // subtraction result always fits back into histoWidth bits.
            rem_d = ge ? (trial[histoWidth-1:0] - divisor) : trial[histoWidth-1:0];
            low_d = {low_q[PixelSize-1:0], 1'b0};
            quo_d = {quo_q[PixelSize-1:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (done) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            low_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            low_q <= low_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/histeq_lut_builder.sv
// Builds the histogram-equalization remap LUT. On start it walks every bin,
// accumulates the CDF, and writes round((cdf - cdf_min) * MaxLevel / (N - cdf_min))
// for each bin, with a fixed PixelSize+4 cycles per bin.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : histeq_lut_builder_if master (start/cdf_min in, histogram
//                read port, LUT write port, busy/done/dbg_state out)
module histeq_lut_builder
    import histeq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    histeq_lut_builder_if.master   bus
);

    localparam logic [histoWidth-1:0] NPix = histoWidth'(NumPixels);

    state_e                state_q, state_d;
    logic [PixelSize-1:0]  bin_q, bin_d;
    logic [histoWidth-1:0] cdf_q, cdf_d;
    logic [histoWidth-1:0] cdf_min_q, cdf_min_d;
    logic                  zero_q, zero_d;
    logic                  done_q, done_d;

    logic [histoWidth:0]   cdf_sum;
    logic [histoWidth-1:0] cdf_new, cdf_c, denom;
    logic                  single_level, above_min;
    logic [DivWidth-1:0]   numer;
    logic                  div_start, div_done;
    logic [PixelSize:0]    quotient;

    logic                  rd_en, wr_en;
    logic [PixelSize-1:0]  rd_addr, wr_addr, wr_data;

    histeq_seq_divider u_div (
        .clk      (clk),
        .rst      (reset),
        .start    (div_start),
        .dividend (numer),
        .divisor  (denom),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        cdf_d     = cdf_q;
        cdf_min_d = cdf_min_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        div_start = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // Saturating CDF update and divider operands; only consumed in ACC.
        cdf_sum      = {1'b0, cdf_q} + {1'b0, bus.hist_rd_data};
        cdf_new      = cdf_sum[histoWidth] ? '1 : cdf_sum[histoWidth-1:0];
        cdf_c        = (cdf_new > NPix) ? NPix : cdf_new;
        single_level = cdf_min_q >= NPix;
        denom        = single_level ? '0 : (NPix - cdf_min_q);
        above_min    = cdf_c > cdf_min_q;
        // A zero numerator keeps the divider precondition when the result is
        // forced to zero anyway; the +D/2 term gives round-half-up.
        numer = above_min
              ? (DivWidth'(cdf_c - cdf_min_q) * DivWidth'(MaxLevel) + DivWidth'(denom >> 1))
              : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cdf_min_d = bus.cdf_min;
                    cdf_d     = '0;
                    bin_d     = '0;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                rd_en   = 1'b1;
                rd_addr = bin_q;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                cdf_d     = cdf_new;
                zero_d    = !above_min || single_level;
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) state_d = ST_WR;
            end
            ST_WR: begin
                wr_en   = 1'b1;
                wr_addr = bin_q;
                if (zero_q)
                    wr_data = '0;
                else if (quotient > (PixelSize + 1)'(MaxLevel))
                    wr_data = PixelSize'(MaxLevel);
                else
                    wr_data = quotient[PixelSize-1:0];
                if (bin_q == PixelSize'(MaxLevel)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    bin_d   = bin_q + 1'b1;
                    state_d = ST_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            cdf_q     <= '0;
            cdf_min_q <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            cdf_q     <= cdf_d;
            cdf_min_q <= cdf_min_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    // Outputs decode from registered state, so an asynchronous reset clears
    // them without waiting for a clock edge.
    assign bus.hist_rd_en   = rd_en;
    assign bus.hist_rd_addr = rd_addr;
    assign bus.lut_wr_en    = wr_en;
    assign bus.lut_wr_addr  = wr_addr;
    assign bus.lut_wr_data  = wr_data;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_histeq_lut_builder.sv
module tb_histeq_lut_builder;
  import histeq_pkg::*;

  localparam int N        = NumPixels;
  localparam int SWEEP    = NumBins * (PixelSize + 4) + 1;
  localparam int BIN_CYC  = PixelSize + 4;

  logic clk;
  logic reset;
  histeq_lut_builder_if bus ();

  histeq_lut_builder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- histogram memory model ----------------
  int hist_mem [NumBins];
  always @(posedge clk)
    if (bus.hist_rd_en) bus.hist_rd_data <= histoWidth'(hist_mem[bus.hist_rd_addr]);

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  bit done_seen = 0;
  bit first_wr = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per LUT write and checks write spacing.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.lut_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("wr_addr", bus.lut_wr_addr, e[15:8]);
          check("wr_data", bus.lut_wr_data, e[7:0]);
        end
        if (first_wr) check("first_wr_latency", cyc - start_cyc + 1, BIN_CYC);
        else          check("wr_spacing", cyc - last_wr_cyc, BIN_CYC);
        first_wr = 0;
        last_wr_cyc = cyc;
      end
      if (bus.done) begin
        check("busy_low_at_done", bus.busy, 0);
        done_seen = 1;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  // Equalized level from the CDF definition: round-half-up of
  // (cdf - cdf_min) * 255 / (N - cdf_min), zero at or below cdf_min.
  task automatic push_model(input int cmin);
    longint cdf = 0;
    longint cc, d, e;
    for (int b = 0; b < NumBins; b++) begin
      cdf += hist_mem[b];
      if (cdf > (1 << histoWidth) - 1) cdf = (1 << histoWidth) - 1;
      cc = (cdf > N) ? N : cdf;
      if (cmin >= N || cc <= cmin) e = 0;
      else begin
        d = N - cmin;
        e = ((cc - cmin) * MaxLevel + d / 2) / d;
        if (e > MaxLevel) e = MaxLevel;
      end
      exp_q.push_back({8'(b), 8'(e)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_hist();
    for (int b = 0; b < NumBins; b++) hist_mem[b] = 0;
  endtask

  task automatic gen_random(output int cmin);
    int remaining, nz, v;
    clear_hist();
    remaining = N;
    nz = $urandom_range(1, 40);
    for (int k = 0; k < nz - 1; k++) begin
      v = $urandom_range(0, remaining);
      hist_mem[$urandom_range(0, NumBins - 1)] += v;
      remaining -= v;
    end
    hist_mem[$urandom_range(0, NumBins - 1)] += remaining;
    cmin = 0;
    for (int b = NumBins - 1; b >= 0; b--) if (hist_mem[b] != 0) cmin = hist_mem[b];
  endtask

  task automatic do_reset_check();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.hist_rd_en, 0);
    check("rst_wr_en", bus.lut_wr_en, 0);
  endtask

  // One sweep. mid_start pulses a bogus start ~40 cycles in; reset_at > 0
  // aborts the sweep with an asynchronous reset that many cycles in.
  task automatic run_sweep(input int cmin, input bit mid_start, input int reset_at);
    done_seen = 0;
    first_wr = 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.cdf_min = histoWidth'(cmin);
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("first_rd_en", bus.hist_rd_en, 1);
    check("first_rd_addr", bus.hist_rd_addr, 0);
    if (reset_at > 0) begin
      repeat (reset_at - 2) @(negedge clk);
      do_reset_check();
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      return;
    end
    for (int i = 0; i < SWEEP + 100 && !done_seen; i++) begin
      @(negedge clk);
      if (mid_start && i == 38) begin
        bus.start = 1'b1;
        bus.cdf_min = histoWidth'($urandom_range(0, N));
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("done_seen", done_seen, 1);
    if (done_seen) check("done_latency", done_cyc - start_cyc + 1, SWEEP);
    check("exp_q_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cmin;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cdf_min = '0;
    bus.hist_rd_data = '0;
    clear_hist();
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rd_en", bus.hist_rd_en, 0);
    check("reset_wr_en", bus.lut_wr_en, 0);
    check("reset_wr_data", bus.lut_wr_data, 0);
    check("reset_state", bus.dbg_state, ST_IDLE);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Uniform: lut[v] = v; a stray start mid-run must not disturb it.
    for (int b = 0; b < NumBins; b++) hist_mem[b] = 1200;
    for (int b = 0; b < NumBins; b++) exp_q.push_back({8'(b), 8'(b)});
    run_sweep(1200, 1, 0);

    // Single level: everything maps to 0.
    clear_hist();
    hist_mem[100] = N;
    for (int b = 0; b < NumBins; b++) exp_q.push_back({8'(b), 8'd0});
    run_sweep(N, 0, 0);

    // Two levels: 0 below bin 200, 255 from there on.
    clear_hist();
    hist_mem[10] = N / 2;
    hist_mem[200] = N / 2;
    for (int b = 0; b < NumBins; b++) exp_q.push_back({8'(b), (b < 200) ? 8'd0 : 8'd255});
    run_sweep(N / 2, 0, 0);

    // Rounding: an exact half at bin 1 rounds up.
    clear_hist();
    hist_mem[0] = 306690;
    hist_mem[1] = 1;
    hist_mem[2] = 509;
    for (int b = 0; b < NumBins; b++)
      exp_q.push_back({8'(b), (b == 0) ? 8'd0 : (b == 1) ? 8'd1 : 8'd255});
    run_sweep(306690, 0, 0);

    // Reset mid-sweep, then a clean uniform sweep.
    for (int b = 0; b < NumBins; b++) hist_mem[b] = 1200;
    for (int b = 0; b < NumBins; b++) exp_q.push_back({8'(b), 8'(b)});
    run_sweep(1200, 0, 500);
    for (int b = 0; b < NumBins; b++) exp_q.push_back({8'(b), 8'(b)});
    run_sweep(1200, 0, 0);

    // Randomized histograms against the reference model.
    for (int t = 0; t < 6; t++) begin
      gen_random(cmin);
      push_model(cmin);
      run_sweep(cmin, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
